// File: rtl/safe_ctrl.sv
// safe_ctrl: keypad combination lock with code change, entry timeout and lockout after repeated failures
module safe_ctrl #(
  parameter int          CODE_LEN       = 4,
  parameter logic [31:0] DEFAULT_CODE   = 32'h0000_1234,
  parameter int          MAX_TRIES      = 3,
  parameter int          LOCKOUT_CYCLES = 250_000_000,
  parameter int          ENTRY_TIMEOUT  = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  input  logic       key_validn,
  output logic       locked,
  output logic       unlock_pulse,
  output logic       alarm,
  output logic [2:0] digit_count,
  output logic [2:0] tries,
  output logic [2:0] state_dbg
);
  localparam int W = 4 * CODE_LEN;
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam int IW = $clog2(ENTRY_TIMEOUT + 1);
  localparam logic [W-1:0] DEF = DEFAULT_CODE[W-1:0];
  typedef enum logic [2:0] {
    UNLOCKED = 3'd0, SET_NEW = 3'd1, LOCKED = 3'd2, ENTRY = 3'd3, CHECK = 3'd4, LOCKOUT = 3'd5
  } state_t;
  state_t state;
  logic prev_n;
  logic [W-1:0] code_r, buf_r, shifted;
  logic [LW-1:0] lock_cnt;
  logic [IW-1:0] idle;
  logic ev, digit, lock_k, clr_k, set_k, last, timing, tmo;
  assign ev = prev_n & ~key_validn;
  assign digit = ev && key_code < 4'd10;
  assign lock_k = ev && key_code == 4'hA;
  assign clr_k = ev && key_code == 4'hC;
  assign set_k = ev && key_code == 4'hF;
  assign shifted = W'({buf_r, key_code});
  assign last = digit_count == 3'(CODE_LEN - 1);
  assign timing = state == ENTRY || state == SET_NEW;
  // a key event in the same cycle always wins over the timeout
  assign tmo = timing && !ev && idle == IW'(ENTRY_TIMEOUT - 1);
  assign state_dbg = state;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= UNLOCKED;
      prev_n <= 1'b1;
      code_r <= DEF;
      buf_r <= '0;
      digit_count <= '0;
      tries <= '0;
      lock_cnt <= '0;
      idle <= '0;
      unlock_pulse <= 1'b0;
      alarm <= 1'b0;
      locked <= 1'b0;
    end else begin
      prev_n <= key_validn;
      unlock_pulse <= 1'b0;
      idle <= (ev || !timing || tmo) ? '0 : idle + IW'(!(&idle));
      case (state)
        UNLOCKED:
          if (lock_k) begin
            state <= LOCKED;
            locked <= 1'b1;
          end else if (set_k) begin
            state <= SET_NEW;
            buf_r <= '0;
            digit_count <= '0;
          end
        SET_NEW:
          if (tmo || lock_k || (digit && last)) begin
            state <= UNLOCKED;
            buf_r <= '0;
            digit_count <= '0;
            if (digit) code_r <= shifted;
          end else if (clr_k) begin
            buf_r <= '0;
            digit_count <= '0;
          end else if (digit) begin
            buf_r <= shifted;
            digit_count <= digit_count + 3'd1;
          end
        LOCKED:
          if (digit) begin
            buf_r <= W'(key_code);
            digit_count <= 3'd1;
            state <= CODE_LEN == 1 ? CHECK : ENTRY;
          end
        ENTRY:
          if (tmo || clr_k) begin
            state <= LOCKED;
            buf_r <= '0;
            digit_count <= '0;
          end else if (digit) begin
            buf_r <= shifted;
            digit_count <= digit_count + 3'd1;
            if (last) state <= CHECK;
          end
        CHECK: begin
          buf_r <= '0;
          digit_count <= '0;
          if (buf_r == code_r) begin
            state <= UNLOCKED;
            locked <= 1'b0;
            unlock_pulse <= 1'b1;
            tries <= '0;
          end else if (int'(tries) + 1 >= MAX_TRIES) begin
            state <= LOCKOUT;
            alarm <= 1'b1;
            tries <= '0;
            lock_cnt <= LW'(LOCKOUT_CYCLES - 1);
          end else begin
            state <= LOCKED;
            tries <= tries + 3'd1;
          end
        end
        LOCKOUT:
          if (lock_cnt == '0) begin
            state <= LOCKED;
            alarm <= 1'b0;
          end else lock_cnt <= lock_cnt - 1'b1;
        default: begin
          state <= UNLOCKED;
          locked <= 1'b0;
          alarm <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_safe_ctrl.sv
// tb_safe_ctrl: scoreboard bench; expected output snapshots are queued by stimulus and popped on every DUT state change or unlock strobe
module tb_safe_ctrl;
  logic clk = 1'b0, rst = 1'b1, key_validn = 1'b1;
  logic [3:0] key_code = 4'h0;
  logic locked, unlock_pulse, alarm;
  logic [2:0] digit_count, tries, state_dbg;
  logic [12:0] cur;
  int pass_n = 0, total_n = 0;
  typedef struct { string nm; logic [12:0] v; } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  safe_ctrl #(.LOCKOUT_CYCLES(20), .ENTRY_TIMEOUT(30)) dut (
    .clk(clk), .rst(rst), .key_code(key_code), .key_validn(key_validn),
    .locked(locked), .unlock_pulse(unlock_pulse), .alarm(alarm),
    .digit_count(digit_count), .tries(tries), .state_dbg(state_dbg)
  );

  assign cur = {state_dbg, locked, alarm, digit_count, tries, unlock_pulse};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] e);
    total_n++;
    if (act === e) pass_n++;
    else $display("FAIL %s: got %0h want %0h", nm, act, e);
  endtask

  task automatic ex(input string nm, input logic [2:0] st, input logic lk, input logic al,
                    input logic [2:0] dc, input logic [2:0] tr, input logic up);
    exp_t e;
    e.nm = nm;
    e.v = {st, lk, al, dc, tr, up};
    q.push_back(e);
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_code = k;
    key_validn = 1'b0;
    repeat (2) @(negedge clk);
    key_validn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic code4(input logic [15:0] c);
    for (int i = 0; i < 4; i++) press(c[15-4*i -: 4]);
  endtask

  task automatic ok_seq(input logic [2:0] tr);
    ex("entry", 3'd3, 1, 0, 3'd1, tr, 0);
    ex("check", 3'd4, 1, 0, 3'd4, tr, 0);
    ex("unlock", 3'd0, 0, 0, 3'd0, 3'd0, 1);
  endtask

  task automatic bad_seq(input logic [2:0] tr);
    ex("entry", 3'd3, 1, 0, 3'd1, tr, 0);
    ex("check", 3'd4, 1, 0, 3'd4, tr, 0);
    if (tr == 3'd2) ex("lockout", 3'd5, 1, 1, 3'd0, 3'd0, 0);
    else ex("relock", 3'd2, 1, 0, 3'd0, tr + 3'd1, 0);
  endtask

  task automatic wait_st(input logic [2:0] s);
    int n = 0;
    while (state_dbg !== s && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_state", state_dbg, s);
  endtask

  // monitor: pops one expectation per observed output change, and times CHECK and LOCKOUT
  initial begin
    logic [2:0] last;
    int dwell;
    exp_t e;
    last = 3'h7;
    dwell = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (state_dbg !== last || unlock_pulse) begin
          if (last == 3'd5) chk("lockout_len", dwell, 20);
          if (last == 3'd4) chk("check_len", dwell, 1);
          if (q.size() == 0) begin
            total_n++;
            $display("FAIL unexpected_output: got %b want none", cur);
          end else begin
            e = q.pop_front();
            chk(e.nm, 32'(cur), 32'(e.v));
          end
          last = state_dbg;
          dwell = 1;
        end else dwell++;
      end
    end
  end

  initial begin
    ex("reset", 3'd0, 0, 0, 3'd0, 3'd0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    ex("lock", 3'd2, 1, 0, 3'd0, 3'd0, 0);
    press(4'hA);
    ok_seq(3'd0);
    code4(16'h1234);
    repeat (3) @(negedge clk);
    chk("s1_locked", locked, 0);
    chk("s1_tries", tries, 0);
    ex("lock", 3'd2, 1, 0, 3'd0, 3'd0, 0);
    press(4'hA);
    bad_seq(3'd0);
    code4(16'h1235);
    chk("s2_tries1", tries, 1);
    bad_seq(3'd1);
    code4(16'h1235);
    chk("s2_tries2", tries, 2);
    bad_seq(3'd2);
    code4(16'h1235);
    chk("s2_alarm_on", alarm, 1);
    ex("lockout_end", 3'd2, 1, 0, 3'd0, 3'd0, 0);
    press(4'h1);
    press(4'h2);
    press(4'hA);
    wait_st(3'd2);
    chk("s2_alarm_off", alarm, 0);
    ok_seq(3'd0);
    code4(16'h1234);
    ex("set_new", 3'd1, 0, 0, 3'd0, 3'd0, 0);
    press(4'hF);
    ex("new_code", 3'd0, 0, 0, 3'd0, 3'd0, 0);
    code4(16'h9876);
    ex("lock", 3'd2, 1, 0, 3'd0, 3'd0, 0);
    press(4'hA);
    bad_seq(3'd0);
    code4(16'h1234);
    chk("s3_tries", tries, 1);
    ok_seq(3'd1);
    code4(16'h9876);
    ex("lock", 3'd2, 1, 0, 3'd0, 3'd0, 0);
    press(4'hA);
    bad_seq(3'd0);
    code4(16'h1111);
    ex("t_entry", 3'd3, 1, 0, 3'd1, 3'd1, 0);
    press(4'h1);
    press(4'h2);
    repeat (20) @(negedge clk);
    chk("no_early_timeout", state_dbg, 3);
    chk("t_count", digit_count, 2);
    ex("timeout", 3'd2, 1, 0, 3'd0, 3'd1, 0);
    repeat (20) @(negedge clk);
    chk("t_state", state_dbg, 2);
    chk("t_count_clr", digit_count, 0);
    chk("t_tries", tries, 1);
    ex("h_entry", 3'd3, 1, 0, 3'd1, 3'd1, 0);
    press(4'h5);
    ex("h_timeout", 3'd2, 1, 0, 3'd0, 3'd1, 0);
    @(negedge clk);
    key_code = 4'h2;
    key_validn = 1'b0;
    repeat (10) @(negedge clk);
    chk("held_count", digit_count, 2);
    repeat (990) @(negedge clk);
    key_validn = 1'b1;
    repeat (2) @(negedge clk);
    chk("held_state", state_dbg, 2);
    chk("held_count_clr", digit_count, 0);
    ex("r_entry", 3'd3, 1, 0, 3'd1, 3'd1, 0);
    press(4'h1);
    press(4'h2);
    press(4'h3);
    chk("pre_rst_count", digit_count, 3);
    ex("rst_mid", 3'd0, 0, 0, 3'd0, 3'd0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_state", state_dbg, 0);
    chk("rst_count", digit_count, 0);
    chk("rst_locked", locked, 0);
    chk("rst_tries", tries, 0);
    ex("lock", 3'd2, 1, 0, 3'd0, 3'd0, 0);
    press(4'hA);
    press(4'hB);
    ex("c_entry", 3'd3, 1, 0, 3'd1, 3'd0, 0);
    press(4'h7);
    ex("clear", 3'd2, 1, 0, 3'd0, 3'd0, 0);
    press(4'hC);
    ok_seq(3'd0);
    code4(16'h1234);
    repeat (5) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/safe_ctrl.md
SAFE_CTRL -- requirements
Module: safe_ctrl

Interface
REQ-001 The block SHALL have parameter CODE_LEN, default 4, meaning the number of digits in the combination (range 1..8).
REQ-002 The block SHALL have parameter DEFAULT_CODE, default 32'h0000_1234, meaning the reset combination; the low 4*CODE_LEN bits are used, first digit most significant.
REQ-003 The block SHALL have parameter MAX_TRIES, default 3, meaning the number of consecutive wrong entries that triggers lockout (range 1..7).
REQ-004 The block SHALL have parameter LOCKOUT_CYCLES, default 250_000_000, meaning the lockout duration in clk cycles.
REQ-005 The block SHALL have parameter ENTRY_TIMEOUT, default 500_000_000, meaning the number of idle clk cycles after which a partial entry is abandoned.
REQ-006 The block SHALL have one clock and a synchronous, active-high reset: port clk, input, 1, the system clock, all state on its rising edge.
REQ-007 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 The block SHALL have port key_code, input, 4, the keypad code 0x0-0xF, valid while key_validn is low.
REQ-009 The block SHALL have port key_validn, input, 1, active low, held low for the duration of a debounced key press.
REQ-010 The block SHALL have port locked, output, 1, which is 1 while the safe is locked.
REQ-011 The block SHALL have port unlock_pulse, output, 1, a one-cycle strobe on a successful unlock.
REQ-012 The block SHALL have port alarm, output, 1, which is 1 during lockout.
REQ-013 The block SHALL have port digit_count, output, 3, the number of digits currently buffered.
REQ-014 The block SHALL have port tries, output, 3, the number of consecutive failed entries.
REQ-015 The block SHALL have port state_dbg, output, 3, the state encoding: UNLOCKED=0, SET_NEW=1, LOCKED=2, ENTRY=3, CHECK=4, LOCKOUT=5.

Function
REQ-016 The block SHALL register key_validn into prev_n; a key event SHALL occur in a cycle where prev_n=1 and key_validn=0, with key_code sampled in that cycle; a held key SHALL produce exactly one event.
REQ-017 The block SHALL treat digit keys as codes 0x0-0x9, LOCK as 0xA, CLEAR as 0xC and SETCODE as 0xF; all other codes SHALL be ignored in every state.
REQ-018 In UNLOCKED, a LOCK event SHALL move the block to LOCKED; a SETCODE event SHALL move it to SET_NEW with the buffer and digit_count cleared; all other events SHALL be ignored.
REQ-019 In SET_NEW, each digit event SHALL shift the digit into the buffer LSB side and increment digit_count.
REQ-020 In SET_NEW, on the CODE_LEN-th digit, the stored code SHALL be loaded with the completed buffer, digit_count SHALL clear, and the block SHALL return to UNLOCKED.
REQ-021 In SET_NEW, CLEAR SHALL zero the buffer and digit_count and the block SHALL stay in SET_NEW; LOCK SHALL abort to UNLOCKED with the stored code unchanged.
REQ-022 In LOCKED, a digit event SHALL load the buffer with the digit, set digit_count=1 and move to ENTRY, or move directly to CHECK if CODE_LEN=1; other events SHALL be ignored.
REQ-023 In ENTRY, digit events SHALL shift and increment the count; on the CODE_LEN-th digit the block SHALL move to CHECK.
REQ-024 In ENTRY, CLEAR SHALL return the block to LOCKED with the buffer and count cleared and tries unchanged.
REQ-025 The idle counter SHALL reset on every key event and SHALL count cycles spent in ENTRY or SET_NEW.
REQ-026 On reaching ENTRY_TIMEOUT, ENTRY SHALL return to LOCKED and SET_NEW SHALL return to UNLOCKED; the buffer and count SHALL clear, and tries SHALL not be incremented.
REQ-027 CHECK SHALL last exactly one cycle and compare the buffer with the stored code; key events arriving in CHECK SHALL be ignored.
REQ-028 On a CHECK match, the block SHALL move to UNLOCKED, pulse unlock_pulse for one cycle (the cycle after CHECK), and clear tries.
REQ-029 On a CHECK mismatch where tries+1 < MAX_TRIES, tries SHALL increment and the block SHALL move to LOCKED.
REQ-030 On a CHECK mismatch where tries+1 = MAX_TRIES, the block SHALL move to LOCKOUT, clear tries, and load the lockout counter.
REQ-031 In every path out of CHECK, the buffer and digit_count SHALL clear.
REQ-032 In LOCKOUT, all key events SHALL be ignored; after LOCKOUT_CYCLES cycles the block SHALL move to LOCKED.
REQ-033 The locked output SHALL be 0 in UNLOCKED and SET_NEW, and 1 otherwise; alarm SHALL be 1 only in LOCKOUT; all outputs SHALL be registered.
REQ-034 The counters SHALL be sized by $clog2 of their parameter and SHALL saturate without wrap.

Reset
REQ-035 Reset SHALL put the block in UNLOCKED, load the stored code with DEFAULT_CODE, set prev_n=1, and clear the buffer, digit_count, tries, all counters, unlock_pulse and alarm; locked SHALL be 0.
REQ-036 Reset asserted in any state, including mid-entry and LOCKOUT, SHALL take precedence over every event in the same cycle.

Verification (bench uses LOCKOUT_CYCLES=20, ENTRY_TIMEOUT=30)
REQ-037 The bench SHALL cover: reset, then press A, then keys 1,2,3,4 -> locked 0->1, then unlock_pulse one cycle after CHECK, locked=0, tries=0.
REQ-038 The bench SHALL cover: locked, enter 1,2,3,5 three times -> tries 1 then 2, then alarm=1 for 20 cycles; keys pressed during lockout are ignored; then state_dbg=2.
REQ-039 The bench SHALL cover: unlocked, press F then 9,8,7,6, then A, then 1,2,3,4 -> tries=1; then 9,8,7,6 -> unlock_pulse.
REQ-040 The bench SHALL cover: locked, enter 1,2 then no key for 30 cycles -> state_dbg=2, digit_count=0, tries unchanged.
REQ-041 The bench SHALL cover: key_validn held low for 1000 cycles on a digit -> digit_count increments by exactly 1.
REQ-042 The bench SHALL cover: rst pulsed in ENTRY with digit_count=3 -> next cycle state_dbg=0, digit_count=0, locked=0, stored code reset to 1234.
